// File: rtl/iir_biquad_cascade.sv
// Time-multiplexed cascade of Direct-Form-I biquads sharing one multiplier-accumulator.
// Each stage output is rounded half-up and saturated before feeding the next stage.
module iir_biquad_cascade #(
    parameter int unsigned W      = 16,
    parameter int unsigned CW     = 16,
    parameter int unsigned FRAC   = 14,
    parameter int unsigned STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic signed [W-1:0]               X,
    input  logic                              clear,
    input  logic                              coef_we,
    input  logic [$clog2(5*STAGES)-1:0]       coef_addr,
    input  logic signed [CW-1:0]              coef_wdata,
    output logic                              busy,
    output logic                              valid,
    output logic                              overrun,
    output logic signed [W-1:0]               Y
);

    localparam int unsigned NCOEF = 5 * STAGES;
    localparam int unsigned AW    = $clog2(NCOEF);
    localparam int unsigned SW    = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int unsigned PW    = W + CW;
    localparam int unsigned ACCW  = W + CW + 4;

    localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [ACCW-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic signed [CW-1:0]   B0_UNITY = CW'(1) << FRAC;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic [SW-1:0]            stage_q;
    logic [2:0]               k_q;
    logic [AW-1:0]            cidx_q;
    logic signed [ACCW-1:0]   acc_q;
    logic signed [W-1:0]      xin_q;
    logic signed [W-1:0]      result_q;

    logic signed [CW-1:0]     coef [NCOEF];
    logic signed [W-1:0]      x1 [STAGES];
    logic signed [W-1:0]      x2 [STAGES];
    logic signed [W-1:0]      y1 [STAGES];
    logic signed [W-1:0]      y2 [STAGES];

    logic signed [CW-1:0]     coef_op;
    logic signed [W-1:0]      data_op;
    logic signed [PW-1:0]     prod;
    logic signed [ACCW-1:0]   acc_nxt;
    logic signed [ACCW-1:0]   rnd;
    logic signed [W-1:0]      sat;
    logic                     last_mac;

    // Operand select: b0..b2 pair with stage input/history, a1/a2 with output history
    always_comb begin
        coef_op = coef[cidx_q];
        data_op = xin_q;
        case (k_q)
            3'd1:    data_op = x1[stage_q];
            3'd2:    data_op = x2[stage_q];
            3'd3:    data_op = y1[stage_q];
            3'd4:    data_op = y2[stage_q];
            default: data_op = xin_q;
        endcase
    end

    // Shared MAC, feedback products subtracted, then round half-up and saturate
    always_comb begin
        prod    = PW'(coef_op) * PW'(data_op);
        acc_nxt = (k_q >= 3'd3) ? (acc_q - ACCW'(prod)) : (acc_q + ACCW'(prod));
        rnd     = (acc_nxt + RND_HALF) >>> FRAC;
        if (rnd > SAT_MAX) begin
            sat = {1'b0, {(W-1){1'b1}}};
        end else if (rnd < SAT_MIN) begin
            sat = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat = W'(rnd);
        end
    end

    assign last_mac = (k_q == 3'd4) && (stage_q == SW'(STAGES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = MAC;
            MAC:     if (last_mac) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, coefficient bank, histories and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q  <= '0;
            k_q      <= '0;
            cidx_q   <= '0;
            acc_q    <= '0;
            xin_q    <= '0;
            result_q <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            Y        <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
            for (int unsigned i = 0; i < NCOEF; i++) begin
                coef[i] <= (i % 5 == 0) ? B0_UNITY : '0;
            end
        end else begin
            busy    <= (state_d != IDLE);
            valid   <= (state_q == DONE);
            overrun <= en && (state_q != IDLE);
            if (state_q == DONE) begin
                Y <= result_q;
            end
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        for (int unsigned s = 0; s < STAGES; s++) begin
                            x1[s] <= '0;
                            x2[s] <= '0;
                            y1[s] <= '0;
                            y2[s] <= '0;
                        end
                    end
                    if (coef_we && (coef_addr < AW'(NCOEF))) begin
                        coef[coef_addr] <= coef_wdata;
                    end
                    if (en) begin
                        xin_q   <= X;
                        acc_q   <= '0;
                        stage_q <= '0;
                        k_q     <= '0;
                        cidx_q  <= '0;
                    end
                end
                MAC: begin
                    cidx_q <= cidx_q + AW'(1);
                    if (k_q == 3'd4) begin
                        x2[stage_q] <= x1[stage_q];
                        x1[stage_q] <= xin_q;
                        y2[stage_q] <= y1[stage_q];
                        y1[stage_q] <= sat;
                        xin_q       <= sat;
                        acc_q       <= '0;
                        k_q         <= '0;
                        stage_q     <= stage_q + SW'(1);
                        if (last_mac) begin
                            result_q <= sat;
                        end
                    end else begin
                        acc_q <= acc_nxt;
                        k_q   <= k_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Bench for iir_biquad_cascade: per-sample arithmetic model checked every cycle,
// plus directed samples with hand-computed outputs.
module tb_iir_biquad_cascade;

    localparam int unsigned W      = 16;
    localparam int unsigned CW     = 16;
    localparam int unsigned FRAC   = 14;
    localparam int unsigned STAGES = 2;
    localparam int unsigned NCOEF  = 5 * STAGES;
    localparam int unsigned AW     = $clog2(NCOEF);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic signed [W-1:0]  X;
    logic                 clear;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic                 busy;
    logic                 valid;
    logic                 overrun;
    logic signed [W-1:0]  Y;

    iir_biquad_cascade #(.W(W), .CW(CW), .FRAC(FRAC), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .en(en), .X(X), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .busy(busy), .valid(valid), .overrun(overrun), .Y(Y)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int last_lat = 0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: whole-sample filter evaluation with plain integer arithmetic
    longint cf [NCOEF];
    longint hx1 [STAGES];
    longint hx2 [STAGES];
    longint hy1 [STAGES];
    longint hy2 [STAGES];
    int     busy_cnt = 0;
    longint pend = 0;
    longint exp_y = 0;
    bit     exp_valid = 0;
    bit     exp_overrun = 0;
    bit     exp_busy = 0;
    bit     chk_on = 0;

    function automatic longint rnd_sat(input longint acc);
        longint r;
        longint mx;
        mx = (longint'(1) << (W - 1)) - 1;
        r  = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (r > mx) r = mx;
        if (r < -mx - 1) r = -mx - 1;
        return r;
    endfunction

    function automatic void clear_hist();
        for (int s = 0; s < STAGES; s++) begin
            hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0;
        end
    endfunction

    function automatic void model_reset();
        clear_hist();
        for (int i = 0; i < NCOEF; i++) cf[i] = (i % 5 == 0) ? (longint'(1) << FRAC) : 0;
        busy_cnt = 0;
        exp_y    = 0;
    endfunction

    function automatic longint run_model(input longint xin);
        longint xs;
        longint acc;
        longint r;
        xs = xin;
        for (int s = 0; s < STAGES; s++) begin
            acc = cf[5*s] * xs + cf[5*s+1] * hx1[s] + cf[5*s+2] * hx2[s]
                - cf[5*s+3] * hy1[s] - cf[5*s+4] * hy2[s];
            r = rnd_sat(acc);
            hx2[s] = hx1[s]; hx1[s] = xs;
            hy2[s] = hy1[s]; hy1[s] = r;
            xs = r;
        end
        return xs;
    endfunction

    always @(posedge clk) begin
        exp_valid   = 0;
        exp_overrun = 0;
        if (rst) begin
            model_reset();
        end else if (busy_cnt == 0) begin
            if (clear) clear_hist();
            if (coef_we && coef_addr < NCOEF) cf[coef_addr] = longint'(coef_wdata);
            if (en) begin
                pend     = run_model(longint'(X));
                busy_cnt = NCOEF + 1;
            end
        end else begin
            if (en) exp_overrun = 1;
            busy_cnt--;
            if (busy_cnt == 0) begin
                exp_valid = 1;
                exp_y     = pend;
            end
        end
        exp_busy = (busy_cnt != 0);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_valid", valid, exp_valid);
            check("cyc_overrun", overrun, exp_overrun);
            check("cyc_busy", busy, exp_busy);
            check("cyc_Y", Y, exp_y);
        end
    end

    task automatic wait_valid(output int lat, output bit ok);
        ok  = 0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                ok  = 1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic sample(input string name, input logic signed [W-1:0] xv, input int expy);
        int lat;
        bit ok;
        en = 1'b1;
        X  = xv;
        @(posedge clk);
        #1 en = 1'b0;
        wait_valid(lat, ok);
        last_lat = lat;
        check({name, "_seen"}, ok, 1);
        if (ok) check(name, Y, expy);
    endtask

    task automatic wcoef(input logic [AW-1:0] a, input logic signed [CW-1:0] v);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = v;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        int lat;
        bit ok;
        bit seen;
        rst = 1'b1; en = 1'b0; X = '0; clear = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_Y", Y, 0);

        // Default pass-through and latency
        sample("t1_pass", 16'sd1000, 1000);
        check("t1_latency", last_lat, 11);
        sample("t1_min", -16'sd32768, -32768);

        // FIR half/half on stage 0
        do_clear();
        wcoef(4'd0, 16'sd8192);
        wcoef(4'd1, 16'sd8192);
        sample("t2_imp0", 16'sd16384, 8192);
        sample("t2_imp1", 16'sd0, 8192);
        sample("t2_imp2", 16'sd0, 0);
        sample("t2_round", 16'sd3, 2);

        // Saturation
        wcoef(4'd1, 16'sd0);
        wcoef(4'd0, 16'sd32767);
        sample("t3_sat_hi", 16'sd30000, 32767);
        sample("t3_sat_lo", -16'sd30000, -32768);
        wcoef(4'd0, 16'sd16384);
        sample("t3_after", 16'sd1234, 1234);

        // Recursive decay y = x + 0.5*y1
        do_clear();
        wcoef(4'd3, -16'sd8192);
        sample("t4_y0", 16'sd16384, 16384);
        sample("t4_y1", 16'sd0, 8192);
        sample("t4_y2", 16'sd0, 4096);
        sample("t4_y3", 16'sd0, 2048);
        sample("t4_y4", 16'sd0, 1024);
        clear = 1'b1;
        sample("t4_cleared", 16'sd0, 0);
        clear = 1'b0;
        wcoef(4'd3, 16'sd0);

        // Overrun and coefficient write while busy
        en = 1'b1; X = 16'sd700;
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 en = 1'b1; X = 16'sd555;
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("t5_overrun_hi", overrun, 1);
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'sd0;
        @(negedge clk);
        check("t5_overrun_lo", overrun, 0);
        coef_we = 1'b0;
        wait_valid(lat, ok);
        check("t5_seen", ok, 1);
        if (ok) check("t5_Y", Y, 700);
        sample("t5_coef_kept", 16'sd321, 321);

        // Reset mid-MAC restores pass-through and drops the sample
        wcoef(4'd0, 16'sd8192);
        en = 1'b1; X = 16'sd999;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_Y", Y, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = 1;
        end
        check("t6_no_valid", seen, 0);
        sample("t6_pass", 16'sd500, 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
